// File: rtl/ll_queue_scheduler_if.sv
// Handshake bundle between the queue scheduler, its requesters/consumer and the linked list.
// The scheduler connects through the slave modport; the environment drives the master side.
interface ll_queue_scheduler_if #(
  parameter int NUM_ELEMS = 4,
  parameter int NUM_LISTS = 2,
  parameter int PTR_WIDTH = $clog2(NUM_ELEMS),
  parameter int IDX_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
);
  logic [NUM_LISTS-1:0] enq_req;
  logic [NUM_LISTS-1:0] enq_gnt;
  logic [PTR_WIDTH-1:0] enq_ptr;
  logic                 deq_ready;
  logic                 deq_valid;
  logic [IDX_WIDTH-1:0] deq_list;
  logic [PTR_WIDTH-1:0] deq_ptr;
  logic [NUM_LISTS-1:0] flush_req;
  logic                 flush_busy;
  logic                 flush_done;
  logic [NUM_LISTS-1:0] ll_push;
  logic [NUM_LISTS-1:0] ll_pop;
  logic                 ll_full;
  logic [NUM_LISTS-1:0] ll_empty;
  logic [PTR_WIDTH-1:0] ll_free_ptr;
  logic [PTR_WIDTH-1:0] ll_popped_head;

  modport slave (
    input  enq_req, deq_ready, flush_req, ll_full, ll_empty, ll_free_ptr, ll_popped_head,
    output enq_gnt, enq_ptr, deq_valid, deq_list, deq_ptr, flush_busy, flush_done, ll_push, ll_pop
  );

  modport master (
    output enq_req, deq_ready, flush_req, ll_full, ll_empty, ll_free_ptr, ll_popped_head,
    input  enq_gnt, enq_ptr, deq_valid, deq_list, deq_ptr, flush_busy, flush_done, ll_push, ll_pop
  );
endinterface

// File: rtl/ll_queue_scheduler.sv
// Push/pop scheduler for a shared-memory multi-list linked list: round-robin enqueue,
// weighted round-robin dequeue with per-owner bursts, and a per-list flush sequencer.
module ll_queue_scheduler #(
  parameter int NUM_ELEMS = 4,
  parameter int NUM_LISTS = 2,
  parameter int PTR_WIDTH = $clog2(NUM_ELEMS),
  parameter int IDX_WIDTH = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
  parameter int BURST     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ll_queue_scheduler_if.slave   bus
);

  localparam int CNT_WIDTH = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_WIDTH-1:0] enq_rr_r, enq_rr_s;
  logic [IDX_WIDTH-1:0] deq_rr_r, deq_rr_s;
  logic [IDX_WIDTH-1:0] flush_idx_r, flush_idx_s;
  logic [CNT_WIDTH-1:0] burst_cnt_r, burst_cnt_s;

  logic [NUM_LISTS-1:0] enq_gnt_s;
  logic [NUM_LISTS-1:0] ll_pop_s;
  logic [IDX_WIDTH-1:0] pop_idx_s;
  logic                 flush_done_s;

  logic                 enq_hit_s;
  logic [IDX_WIDTH-1:0] enq_idx_s;
  logic                 sw_hit_s;
  logic [IDX_WIDTH-1:0] sw_idx_s;
  logic                 owner_ok_s;
  logic [NUM_LISTS-1:0] elig_s;
  logic [IDX_WIDTH-1:0] freq_idx_s;

  // Circular list index: base + offs wrapped into [0, NUM_LISTS).
  function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_LISTS) begin
      s = s - NUM_LISTS;
    end else begin
      s = s;
    end
    return IDX_WIDTH'(s);
  endfunction

  // Candidate searches: enqueue from enq_rr, dequeue switch target strictly after deq_rr.
  always_comb begin
    elig_s     = ~bus.ll_empty;
    enq_hit_s  = 1'b0;
    enq_idx_s  = {IDX_WIDTH{1'b0}};
    sw_hit_s   = 1'b0;
    sw_idx_s   = {IDX_WIDTH{1'b0}};
    freq_idx_s = {IDX_WIDTH{1'b0}};
    for (int k = 0; k < NUM_LISTS; k++) begin
      if (!enq_hit_s && bus.enq_req[wrap_add(enq_rr_r, k)]) begin
        enq_hit_s = 1'b1;
        enq_idx_s = wrap_add(enq_rr_r, k);
      end else begin
        enq_hit_s = enq_hit_s;
      end
    end
    // Offset NUM_LISTS wraps back to the owner itself, which then starts a fresh burst.
    for (int k = 1; k <= NUM_LISTS; k++) begin
      if (!sw_hit_s && elig_s[wrap_add(deq_rr_r, k % NUM_LISTS)]) begin
        sw_hit_s = 1'b1;
        sw_idx_s = wrap_add(deq_rr_r, k % NUM_LISTS);
      end else begin
        sw_hit_s = sw_hit_s;
      end
    end
    for (int k = NUM_LISTS - 1; k >= 0; k--) begin
      if (bus.flush_req[k]) begin
        freq_idx_s = IDX_WIDTH'(k);
      end else begin
        freq_idx_s = freq_idx_s;
      end
    end
    owner_ok_s = elig_s[deq_rr_r] && (burst_cnt_r < CNT_WIDTH'(BURST));
  end

  // Next-state and strobe generation for arbitration and the flush FSM.
  always_comb begin
    state_s      = state_r;
    enq_rr_s     = enq_rr_r;
    deq_rr_s     = deq_rr_r;
    flush_idx_s  = flush_idx_r;
    burst_cnt_s  = burst_cnt_r;
    enq_gnt_s    = {NUM_LISTS{1'b0}};
    ll_pop_s     = {NUM_LISTS{1'b0}};
    pop_idx_s    = {IDX_WIDTH{1'b0}};
    flush_done_s = 1'b0;
    if (rst) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enq_hit_s && !bus.ll_full) begin
            enq_gnt_s[enq_idx_s] = 1'b1;
            enq_rr_s             = wrap_add(enq_idx_s, 1);
          end else begin
            enq_rr_s = enq_rr_r;
          end
          if (bus.deq_ready && owner_ok_s) begin
            ll_pop_s[deq_rr_r] = 1'b1;
            pop_idx_s          = deq_rr_r;
            burst_cnt_s        = burst_cnt_r + CNT_WIDTH'(1);
          end else if (bus.deq_ready && sw_hit_s) begin
            ll_pop_s[sw_idx_s] = 1'b1;
            pop_idx_s          = sw_idx_s;
            deq_rr_s           = sw_idx_s;
            burst_cnt_s        = CNT_WIDTH'(1);
          end else begin
            burst_cnt_s = burst_cnt_r;
          end
          if (|bus.flush_req) begin
            state_s     = ST_FLUSH;
            flush_idx_s = freq_idx_s;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (!bus.ll_empty[flush_idx_r]) begin
            ll_pop_s[flush_idx_r] = 1'b1;
            pop_idx_s             = flush_idx_r;
          end else begin
            flush_done_s = 1'b1;
            burst_cnt_s  = {CNT_WIDTH{1'b0}};
            state_s      = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      enq_rr_r    <= {IDX_WIDTH{1'b0}};
      deq_rr_r    <= {IDX_WIDTH{1'b0}};
      flush_idx_r <= {IDX_WIDTH{1'b0}};
      burst_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      enq_rr_r    <= enq_rr_s;
      deq_rr_r    <= deq_rr_s;
      flush_idx_r <= flush_idx_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  assign bus.enq_gnt    = enq_gnt_s;
  assign bus.ll_push    = enq_gnt_s;
  assign bus.enq_ptr    = bus.ll_free_ptr;
  assign bus.ll_pop     = ll_pop_s;
  assign bus.deq_valid  = |ll_pop_s;
  assign bus.deq_list   = pop_idx_s;
  assign bus.deq_ptr    = bus.ll_popped_head;
  assign bus.flush_busy = !rst && (state_r == ST_FLUSH);
  assign bus.flush_done = flush_done_s;

endmodule

// File: tb/tb_ll_queue_scheduler.sv
// Directed, table-driven bench for ll_queue_scheduler; the linked-list status inputs
// are driven straight from the vectors so every expected strobe is hand-computed.
module tb_ll_queue_scheduler;

  localparam int NUM_ELEMS = 4;
  localparam int NUM_LISTS = 2;
  localparam int PTR_WIDTH = 2;
  localparam int IDX_WIDTH = 1;
  localparam int BURST     = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic chk_en;

  ll_queue_scheduler_if #(.NUM_ELEMS(NUM_ELEMS), .NUM_LISTS(NUM_LISTS),
                          .PTR_WIDTH(PTR_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  ll_queue_scheduler #(.NUM_ELEMS(NUM_ELEMS), .NUM_LISTS(NUM_LISTS), .PTR_WIDTH(PTR_WIDTH),
                       .IDX_WIDTH(IDX_WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] enq;
    logic       rdy;
    logic [1:0] flush;
    logic       full;
    logic [1:0] empty;
    logic [1:0] free_ptr;
    logic [1:0] popped;
    logic [1:0] e_gnt;
    logic [1:0] e_pop;
    logic       e_list;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic [1:0] enq, input logic rdy,
                              input logic [1:0] fl, input logic full, input logic [1:0] emp,
                              input logic [1:0] fp, input logic [1:0] ph, input logic [1:0] g,
                              input logic [1:0] p, input logic l, input logic b, input logic d);
    vec_t v;
    v.rst = r; v.enq = enq; v.rdy = rdy; v.flush = fl; v.full = full; v.empty = emp;
    v.free_ptr = fp; v.popped = ph; v.e_gnt = g; v.e_pop = p; v.e_list = l;
    v.e_busy = b; v.e_done = d;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [1:0] enq, input logic rdy,
                       input logic [1:0] fl, input logic full, input logic [1:0] emp,
                       input logic [1:0] fp, input logic [1:0] ph);
    rst = r;
    bus.enq_req = enq; bus.deq_ready = rdy; bus.flush_req = fl; bus.ll_full = full;
    bus.ll_empty = emp; bus.ll_free_ptr = fp; bus.ll_popped_head = ph;
  endtask

  task automatic chk(input int idx, input string name, input logic [3:0] act, input logic [3:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  // Structural invariants on the linked-list strobes, checked every cycle while enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!$onehot0(bus.ll_push)) begin
        n_err++;
        $display("FAIL inv push_onehot: ll_push=%b", bus.ll_push);
      end
      if (!$onehot0(bus.ll_pop)) begin
        n_err++;
        $display("FAIL inv pop_onehot: ll_pop=%b", bus.ll_pop);
      end
      if ((|bus.ll_push) && bus.ll_full) begin
        n_err++;
        $display("FAIL inv push_full: ll_push=%b while full", bus.ll_push);
      end
      if (|(bus.ll_pop & bus.ll_empty)) begin
        n_err++;
        $display("FAIL inv pop_empty: ll_pop=%b ll_empty=%b", bus.ll_pop, bus.ll_empty);
      end
    end
  end

  initial begin
    int   cnt1;
    int   pops;
    logic done_seen;
    logic busy_seen;
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11, 2'd0, 2'd0);

    //        rst  enq    rdy  flush  full  empty  free   popd   gnt    pop    lst  bsy  done
    // reset gating, enqueue rotation and enq_ptr passthrough
    vq.push_back(mk(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b11, 2'd0, 2'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b10, 2'd1, 2'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'd2, 2'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'd3, 2'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
    // full: no grant, not even with a pop in the same cycle; grant resumes afterwards
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b1, 2'b00, 2'd0, 2'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0));
    // reset again, then burst sequence 0,0,1,1,0,1
    vq.push_back(mk(1'b1, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd2, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 2'd0, 2'd2, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b11, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    // deq_ready low holds burst state; owner 1 continues its burst afterwards
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0));
    // push and pop of list 0 in one cycle, then pop returns the new element
    vq.push_back(mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 2'b10, 2'd2, 2'd1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b10, 2'd0, 2'd2, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    // flush list 1 holding two elements; second flush_req while busy ignored
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 2'b00, 2'd0, 2'd2, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
    // burst counter cleared by the flush: owner 0 gets two fresh pops
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd3, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0));
    // flush of an already-empty list
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 2'b01, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b01, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    // reset in the middle of a flush
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'd0, 2'd1, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'd2, 2'd3, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0));

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].enq, vq[i].rdy, vq[i].flush, vq[i].full, vq[i].empty,
            vq[i].free_ptr, vq[i].popped);
      @(negedge clk);
      n_vec++;
      chk(i, "enq_gnt", {2'b00, bus.enq_gnt}, {2'b00, vq[i].e_gnt});
      chk(i, "ll_push", {2'b00, bus.ll_push}, {2'b00, vq[i].e_gnt});
      chk(i, "ll_pop", {2'b00, bus.ll_pop}, {2'b00, vq[i].e_pop});
      chk(i, "deq_valid", {3'b000, bus.deq_valid}, {3'b000, |vq[i].e_pop});
      chk(i, "flush_busy", {3'b000, bus.flush_busy}, {3'b000, vq[i].e_busy});
      chk(i, "flush_done", {3'b000, bus.flush_done}, {3'b000, vq[i].e_done});
      if (|vq[i].e_gnt) begin
        chk(i, "enq_ptr", {2'b00, bus.enq_ptr}, {2'b00, vq[i].free_ptr});
      end
      if (|vq[i].e_pop) begin
        chk(i, "deq_list", {3'b000, bus.deq_list}, {3'b000, vq[i].e_list});
        chk(i, "deq_ptr", {2'b00, bus.deq_ptr}, {2'b00, vq[i].popped});
      end
      @(posedge clk);
      #1;
    end

    // Hand sequence: list 1 holds 3 elements, flush drains it with deq_ready low.
    drive(1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b11, 2'd0, 2'd0);
    @(posedge clk);
    #1;
    cnt1      = 3;
    pops      = 0;
    done_seen = 1'b0;
    busy_seen = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 2'b01, 2'd0, 2'd0);
    for (int c = 0; c < 10 && !done_seen; c++) begin
      bus.ll_empty       = {(cnt1 == 0), 1'b1};
      bus.ll_popped_head = 2'(cnt1);
      @(negedge clk);
      if (bus.flush_busy) busy_seen = 1'b1;
      if (bus.ll_pop[1]) begin
        pops++;
        cnt1--;
      end
      if (bus.flush_done) done_seen = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_req = 2'b00;
    end
    n_vec++;
    if (!done_seen) begin
      n_err++;
      $display("FAIL seq flush_done: not seen within 10 cycles, required a pulse");
    end
    n_vec++;
    if (pops != 3) begin
      n_err++;
      $display("FAIL seq flush_pops: got %0d pops, expected 3", pops);
    end
    n_vec++;
    if (!busy_seen) begin
      n_err++;
      $display("FAIL seq flush_busy: got never-busy, expected busy during flush");
    end
    @(negedge clk);
    n_vec++;
    if (bus.flush_busy !== 1'b0) begin
      n_err++;
      $display("FAIL seq busy_clear: got %b expected 0", bus.flush_busy);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
